display_refresh_ctrl: RTL and testbench

DISPLAY_REFRESH_CTRL -- requirements
Module: display_refresh_ctrl

---
 rtl/display_pkg.sv | 27 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/display_refresh_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_display_refresh_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment refresh controller:
// frame width, segment patterns (bit 6 = a .. bit 0 = g), FSM states.
package display_pkg;

    localparam int FRAME_W = 16;

    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h70;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        TRIGGER,
        SHIFTING,
        BLANK
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder, active-high segments a..g (MSB = a).
// Non-decimal codes blank the digit.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // pure lookup; codes 10-15 show nothing
    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Multiplexed 7-segment refresh controller feeding a 595 shifter.
// One digit frame per divider tick; digits update atomically per frame.
module display_refresh_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int SHIFT_CYCLES = 34
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic                    sr_trigger_o,
    output logic [FRAME_W-1:0]      sr_data_o,
    output logic [2:0]              digit_idx_o,
    output logic                    frame_done_o
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(SHIFT_CYCLES + 2);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] DIG_BLANK = {NUM_DIGITS{4'hF}};

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [DW-1:0]           r_div;
    logic [HW-1:0]           r_hold;
    logic [HW-1:0]           w_hold_nx;
    logic [2:0]              r_idx;
    logic [2:0]              r_sent_idx;
    logic                    r_trig;
    logic                    w_trig_nx;
    logic                    r_done;
    logic [FRAME_W-1:0]      r_data;
    logic [4*NUM_DIGITS-1:0] r_sh_dig;
    logic [4*NUM_DIGITS-1:0] r_act_dig;
    logic [4*NUM_DIGITS-1:0] w_sh_dig;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   w_sh_dp;
    logic                    w_tick;
    logic                    w_start;
    logic                    w_load;
    logic                    w_blank;
    logic                    w_adv;
    logic                    w_wrap;
    logic [3:0]              w_bcd;
    logic                    w_dp;
    logic [7:0]              w_sel;
    logic [6:0]              w_seg;

    assign w_tick   = (r_div == DW'(REFRESH_DIV - 1));
    assign w_wrap   = w_adv && (r_idx == LAST);
    assign w_sh_dig = load_i ? digits_i : r_sh_dig;
    assign w_sh_dp  = load_i ? dp_i : r_sh_dp;

    bcd_to_7seg u_dec (
        .i_bcd (w_bcd),
        .o_seg (w_seg)
    );

    // select the active digit, its dp and its one-hot strobe
    always_comb begin
        w_bcd = 4'hF;
        w_dp  = 1'b0;
        w_sel = 8'h00;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_bcd    = r_act_dig[4*k +: 4];
                w_dp     = r_act_dp[k];
                w_sel[k] = 1'b1;
            end
        end
    end

    // next state, trigger request and datapath strobes
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_trig_nx  = 1'b0;
        w_start    = 1'b0;
        w_load     = 1'b0;
        w_blank    = 1'b0;
        w_adv      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_hold_nx = '0;
                if (enable_i) begin
                    w_state_nx = WAIT_TICK;
                    w_start    = 1'b1;
                end
            end
            WAIT_TICK: begin
                if (!enable_i) begin
                    w_state_nx = BLANK;
                    w_trig_nx  = 1'b1;
                    w_blank    = 1'b1;
                    w_hold_nx  = HW'(SHIFT_CYCLES);
                end else if (w_tick) begin
                    w_state_nx = TRIGGER;
                    w_trig_nx  = 1'b1;
                    w_load     = 1'b1;
                end
            end
            TRIGGER: begin
                w_state_nx = SHIFTING;
                w_hold_nx  = HW'(SHIFT_CYCLES);
                w_adv      = 1'b1;
            end
            SHIFTING: begin
                if (r_hold <= HW'(1)) begin
                    w_state_nx = WAIT_TICK;
                    w_hold_nx  = '0;
                end else begin
                    w_hold_nx = r_hold - HW'(1);
                end
            end
            BLANK: begin
                if (!r_trig) begin
                    if (r_hold <= HW'(1)) begin
                        w_state_nx = IDLE;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx = r_hold - HW'(1);
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // state, hold counter and trigger pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_trig  <= w_trig_nx;
        end
    end

    // free-running slot divider, parked at zero while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div <= '0;
        end else if (r_state == IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // digit index and end-of-frame pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_wrap;
            if (r_state == IDLE) begin
                r_idx <= '0;
            end else if (w_adv) begin
                r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    // shadow takes loads at once; active copies it only at frame start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sh_dig  <= DIG_BLANK;
            r_sh_dp   <= '0;
            r_act_dig <= DIG_BLANK;
            r_act_dp  <= '0;
        end else begin
            r_sh_dig <= w_sh_dig;
            r_sh_dp  <= w_sh_dp;
            if (w_start || w_wrap) begin
                r_act_dig <= w_sh_dig;
                r_act_dp  <= w_sh_dp;
            end
        end
    end

    // outgoing frame, held from one trigger to the next
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data     <= '0;
            r_sent_idx <= '0;
        end else if (w_load) begin
            r_data     <= {w_seg, w_dp, w_sel};
            r_sent_idx <= r_idx;
        end else if (w_blank) begin
            r_data <= '0;
        end
    end

    assign sr_trigger_o = r_trig;
    assign sr_data_o    = r_data;
    assign digit_idx_o  = r_sent_idx;
    assign frame_done_o = r_done;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Self-checking bench for display_refresh_ctrl: directed scenarios
// plus random loads/enables against a timing-window reference model.
module tb_display_refresh_ctrl;

    localparam int N    = 4;
    localparam int RD   = 24;
    localparam int SC   = 6;
    localparam int DWID = 4 * N;

    localparam logic [15:0] S_A = 16'h8000;
    localparam logic [15:0] S_B = 16'h4000;
    localparam logic [15:0] S_C = 16'h2000;
    localparam logic [15:0] S_D = 16'h1000;
    localparam logic [15:0] S_E = 16'h0800;
    localparam logic [15:0] S_F = 16'h0400;
    localparam logic [15:0] S_G = 16'h0200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            ld;
    logic [DWID-1:0] dig;
    logic [N-1:0]    dpv;
    logic            trig;
    logic [15:0]     data;
    logic [2:0]      idx;
    logic            done;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_trig = -1;
    int n_done = 0;
    int c_en = 0;
    logic [15:0] q_trig[$];
    int          q_cyc[$];

    logic [3:0]  m_sh[N];
    logic [3:0]  m_act[N];
    logic        m_shdp[N];
    logic        m_actdp[N];
    bit          m_on;
    bit          m_blanking;
    bit          m_wrap_next;
    int          m_t;
    int          m_busy;
    int          m_k;
    logic        e_trig;
    logic [15:0] e_data;
    logic [2:0]  e_idx;
    logic        e_done;

    always #5 clk = ~clk;

    display_refresh_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .SHIFT_CYCLES (SC)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .load_i       (ld),
        .digits_i     (dig),
        .dp_i         (dpv),
        .sr_trigger_o (trig),
        .sr_data_o    (data),
        .digit_idx_o  (idx),
        .frame_done_o (done)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] seg_mask(input logic [3:0] d);
        case (d)
            4'd0:    return S_A | S_B | S_C | S_D | S_E | S_F;
            4'd1:    return S_B | S_C;
            4'd2:    return S_A | S_B | S_G | S_E | S_D;
            4'd3:    return S_A | S_B | S_G | S_C | S_D;
            4'd4:    return S_F | S_G | S_B | S_C;
            4'd5:    return S_A | S_F | S_G | S_C | S_D;
            4'd6:    return S_A | S_F | S_G | S_E | S_C | S_D;
            4'd7:    return S_A | S_B | S_C;
            4'd8:    return S_A | S_B | S_C | S_D | S_E | S_F | S_G;
            4'd9:    return S_A | S_B | S_C | S_D | S_F | S_G;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] frame_of(input logic [3:0] d,
                                             input logic p, input int k);
        logic [15:0] f;
        f = seg_mask(d);
        if (p) f = f | 16'h0100;
        f = f | (16'h0001 << k);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i]    = 4'hF;
            m_act[i]   = 4'hF;
            m_shdp[i]  = 1'b0;
            m_actdp[i] = 1'b0;
        end
        m_on        = 0;
        m_blanking  = 0;
        m_wrap_next = 0;
        m_t         = 0;
        m_busy      = 0;
        m_k         = 0;
        e_trig      = 1'b0;
        e_data      = 16'h0000;
        e_idx       = 3'd0;
        e_done      = 1'b0;
    endtask

    // One clock edge of the reference: after each trigger the unit is
    // busy for 1+SC edges; otherwise it idles, starts, blanks or fires
    // on every RD-th edge since start.
    task automatic model_edge();
        e_trig = 1'b0;
        e_done = 1'b0;
        if (ld) begin
            for (int i = 0; i < N; i++) begin
                m_sh[i]   = dig[4*i +: 4];
                m_shdp[i] = dpv[i];
            end
        end
        if (m_on) m_t++;
        if (m_busy > 0) begin
            if (m_wrap_next) begin
                for (int i = 0; i < N; i++) begin
                    m_act[i]   = m_sh[i];
                    m_actdp[i] = m_shdp[i];
                end
                e_done      = 1'b1;
                m_wrap_next = 0;
            end
            m_busy--;
            if (m_busy == 0 && m_blanking) begin
                m_on       = 0;
                m_blanking = 0;
            end
        end else if (!m_on) begin
            if (en) begin
                m_on = 1;
                m_t  = 0;
                m_k  = 0;
                for (int i = 0; i < N; i++) begin
                    m_act[i]   = m_sh[i];
                    m_actdp[i] = m_shdp[i];
                end
            end
        end else if (!en) begin
            e_trig     = 1'b1;
            e_data     = 16'h0000;
            m_blanking = 1;
            m_busy     = SC + 1;
        end else if (m_t % RD == 0) begin
            e_trig      = 1'b1;
            e_data      = frame_of(m_act[m_k], m_actdp[m_k], m_k);
            e_idx       = 3'(m_k);
            m_wrap_next = (m_k == N - 1);
            m_k         = (m_k + 1) % N;
            m_busy      = SC + 1;
        end
    endtask

    task automatic step();
        int gap;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("trigger", trig, e_trig);
        chk("data", data, e_data);
        chk("digit_idx", idx, e_idx);
        chk("frame_done", done, e_done);
        if (trig) begin
            q_trig.push_back(data);
            q_cyc.push_back(cyc);
            if (last_trig >= 0) begin
                gap = cyc - last_trig;
                chk("spacing", (gap >= SC + 1) ? SC + 1 : gap, SC + 1);
            end
            last_trig = cyc;
        end
        if (done) n_done++;
        ld = 1'b0;
    endtask

    task automatic run_trigs(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < (n + 1) * RD * 2) begin
            step();
            t++;
            if (trig) seen++;
        end
        chk("trigger_timeout", seen, n);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_trigger", trig, 0);
        chk("rst_data", data, 0);
        chk("rst_idx", idx, 0);
        chk("rst_done", done, 0);
        model_reset();
        last_trig = -1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        ld    = 1'b0;
        dig   = '0;
        dpv   = '0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // all-zero digits, first frame
        dig = '0;
        dpv = '0;
        ld  = 1'b1;
        step();
        en   = 1'b1;
        c_en = cyc + 1;
        q_trig.delete();
        q_cyc.delete();
        run_trigs(4);
        chk("first_latency", q_cyc[0] - c_en, RD);
        chk("zero_d0", q_trig[0], 16'hFC01);
        chk("zero_d1", q_trig[1], 16'hFC02);
        chk("zero_d2", q_trig[2], 16'hFC04);
        chk("zero_d3", q_trig[3], 16'hFC08);
        chk("slot_spacing", q_cyc[1] - q_cyc[0], RD);

        // load in the middle of a frame
        q_trig.delete();
        run_trigs(2);
        dig    = 16'h0A18;
        dpv    = 4'b0001;
        ld     = 1'b1;
        n_done = 0;
        run_trigs(6);
        chk("old_d2", q_trig[2], 16'hFC04);
        chk("old_d3", q_trig[3], 16'hFC08);
        chk("new_d0", q_trig[4], 16'hFF01);
        chk("new_d1", q_trig[5], 16'h6002);
        chk("new_d2", q_trig[6], 16'h0004);
        chk("new_d3", q_trig[7], 16'hFC08);
        chk("done_per_wrap", n_done, 1);

        // disable while waiting for a tick
        repeat (SC + 3) step();
        en = 1'b0;
        q_trig.delete();
        repeat (3 * RD) step();
        chk("blank_count", q_trig.size(), 1);
        chk("blank_data", q_trig[0], 16'h0000);

        // reset in the middle of shifting
        en = 1'b1;
        run_trigs(1);
        repeat (3) step();
        apply_reset();
        q_trig.delete();
        repeat (RD - 1) step();
        chk("post_reset_quiet", q_trig.size(), 0);
        run_trigs(1);
        chk("post_reset_first", q_trig[0], 16'h0001);

        // random loads, enable toggles and resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                dig = DWID'($urandom);
                dpv = N'($urandom);
                ld  = 1'b1;
            end
            if ($urandom_range(0, 119) == 0) en = ~en;
            if ($urandom_range(0, 1499) == 0) apply_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
